// File: rtl/light_phase_monitor.sv
// Receive-side phase checker for a two-approach traffic-light controller.
// Optional fault-mode red blinking is enabled by defining LIGHT_PHASE_MONITOR_FLASH_EN.
module light_phase_monitor #(
    parameter int MAX_DWELL = 200,
    parameter int DWELL_W   = 8,
    parameter int FLASH_DIV = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [1:0]         i_light_a,
    input  logic [1:0]         i_light_b,
    input  logic               i_clear,
    output logic [2:0]         o_lamp_a,
    output logic [2:0]         o_lamp_b,
    output logic               o_locked,
    output logic [1:0]         o_phase,
    output logic [DWELL_W-1:0] o_dwell,
    output logic               o_fault,
    output logic [1:0]         o_fault_code
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TRANS   = 2'b01;
    localparam logic [1:0] CODE_PAIR    = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    localparam logic [2:0] LAMP_RED = 3'b100;

    if (MAX_DWELL >= (1 << DWELL_W) || FLASH_DIV < 1) begin : g_bad_params
        $error("light_phase_monitor: MAX_DWELL must fit in DWELL_W bits and FLASH_DIV must be positive");
    end

    // Returns {legal, phase_index} for a sampled code pair.
    function automatic logic [2:0] classify_pair(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] res;
        case ({a, b})
            4'b00_10: res = {1'b1, 2'd0};
            4'b01_11: res = {1'b1, 2'd1};
            4'b10_00: res = {1'b1, 2'd2};
            4'b11_01: res = {1'b1, 2'd3};
            default:  res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            2'b00:   lamp = 3'b001;
            2'b01:   lamp = 3'b010;
            2'b10:   lamp = 3'b100;
            2'b11:   lamp = 3'b110;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    logic [1:0]         state_r, state_s;
    logic [2:0]         lamp_a_r, lamp_a_s;
    logic [2:0]         lamp_b_r, lamp_b_s;
    logic               locked_r, locked_s;
    logic [1:0]         phase_r, phase_s;
    logic [DWELL_W-1:0] dwell_r, dwell_s;
    logic               fault_r, fault_s;
    logic [1:0]         code_r, code_s;

    logic [2:0]         pair_s;
    logic               pair_ok_s;
    logic [1:0]         pair_idx_s;
    logic [1:0]         next_phase_s;
    logic               enter_fault_s;
    logic [1:0]         entry_code_s;

`ifdef LIGHT_PHASE_MONITOR_FLASH_EN
    localparam int BLINK_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_s;
`endif

    assign pair_s       = classify_pair(i_light_a, i_light_b);
    assign pair_ok_s    = pair_s[2];
    assign pair_idx_s   = pair_s[1:0];
    assign next_phase_s = phase_r + 2'd1;

    // Classify the sampled pair against the tracked phase and decide the next state.
    always_comb begin
        state_s       = state_r;
        lamp_a_s      = lamp_a_r;
        lamp_b_s      = lamp_b_r;
        locked_s      = locked_r;
        phase_s       = phase_r;
        dwell_s       = dwell_r;
        fault_s       = fault_r;
        code_s        = code_r;
        enter_fault_s = 1'b0;
        entry_code_s  = CODE_NONE;
`ifdef LIGHT_PHASE_MONITOR_FLASH_EN
        blink_cnt_s   = blink_cnt_r;
`endif
        case (state_r)
            ST_SYNC: begin
                if (pair_ok_s) begin
                    state_s  = ST_RUN;
                    locked_s = 1'b1;
                    phase_s  = pair_idx_s;
                    dwell_s  = '0;
                    lamp_a_s = decode_lamp(i_light_a);
                    lamp_b_s = decode_lamp(i_light_b);
                end else begin
                    lamp_a_s = LAMP_RED;
                    lamp_b_s = LAMP_RED;
                end
            end
            ST_RUN: begin
                if (!pair_ok_s) begin
                    enter_fault_s = 1'b1;
                    entry_code_s  = CODE_PAIR;
                end else if (pair_idx_s == phase_r) begin
                    if (dwell_r == DWELL_W'(MAX_DWELL)) begin
                        enter_fault_s = 1'b1;
                        entry_code_s  = CODE_TIMEOUT;
                    end else begin
                        dwell_s  = dwell_r + {{(DWELL_W-1){1'b0}}, 1'b1};
                        lamp_a_s = decode_lamp(i_light_a);
                        lamp_b_s = decode_lamp(i_light_b);
                    end
                end else if (pair_idx_s == next_phase_s) begin
                    phase_s  = next_phase_s;
                    dwell_s  = '0;
                    lamp_a_s = decode_lamp(i_light_a);
                    lamp_b_s = decode_lamp(i_light_b);
                end else begin
                    enter_fault_s = 1'b1;
                    entry_code_s  = CODE_TRANS;
                end
            end
            ST_FAULT: begin
                if (i_clear) begin
                    state_s  = ST_SYNC;
                    fault_s  = 1'b0;
                    code_s   = CODE_NONE;
                    dwell_s  = '0;
                    lamp_a_s = LAMP_RED;
                    lamp_b_s = LAMP_RED;
                end else begin
`ifdef LIGHT_PHASE_MONITOR_FLASH_EN
                    // Red toggles once every FLASH_DIV cycles spent in FAULT.
                    if (blink_cnt_r == BLINK_W'(FLASH_DIV - 1)) begin
                        blink_cnt_s = '0;
                        lamp_a_s    = {~lamp_a_r[2], 2'b00};
                        lamp_b_s    = {~lamp_b_r[2], 2'b00};
                    end else begin
                        blink_cnt_s = blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
                    end
`else
                    lamp_a_s = LAMP_RED;
                    lamp_b_s = LAMP_RED;
`endif
                end
            end
            default: begin
                state_s  = ST_SYNC;
                locked_s = 1'b0;
                lamp_a_s = LAMP_RED;
                lamp_b_s = LAMP_RED;
            end
        endcase

        // Fault entry freezes phase/dwell and forces red on both approaches.
        if (enter_fault_s) begin
            state_s  = ST_FAULT;
            locked_s = 1'b0;
            fault_s  = 1'b1;
            code_s   = entry_code_s;
            lamp_a_s = LAMP_RED;
            lamp_b_s = LAMP_RED;
`ifdef LIGHT_PHASE_MONITOR_FLASH_EN
            blink_cnt_s = '0;
`endif
        end else begin
            locked_s = (state_s == ST_RUN);
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r  <= ST_SYNC;
            lamp_a_r <= LAMP_RED;
            lamp_b_r <= LAMP_RED;
            locked_r <= 1'b0;
            phase_r  <= 2'd0;
            dwell_r  <= '0;
            fault_r  <= 1'b0;
            code_r   <= CODE_NONE;
        end else begin
            state_r  <= state_s;
            lamp_a_r <= lamp_a_s;
            lamp_b_r <= lamp_b_s;
            locked_r <= locked_s;
            phase_r  <= phase_s;
            dwell_r  <= dwell_s;
            fault_r  <= fault_s;
            code_r   <= code_s;
        end
    end

`ifdef LIGHT_PHASE_MONITOR_FLASH_EN
    // Fault-mode blink counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_s;
        end
    end
`endif

    assign o_lamp_a     = lamp_a_r;
    assign o_lamp_b     = lamp_b_r;
    assign o_locked     = locked_r;
    assign o_phase      = phase_r;
    assign o_dwell      = dwell_r;
    assign o_fault      = fault_r;
    assign o_fault_code = code_r;

endmodule
